// File: rtl/m_seg_decoder_pkg.sv
// Shared segment-pattern and character-code constants used by the character ROMs and the decoder.
// Patterns are active-low g..a (bit 0 = segment a); the decimal point is carried separately.
package m_seg_decoder_pkg;

  localparam int SEG_W  = 7;
  localparam int CODE_W = 5;

  localparam logic [SEG_W-1:0] SEG_0  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1  = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2  = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3  = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4  = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5  = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6  = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7  = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8  = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9  = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A  = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B  = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C  = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D  = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E  = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F  = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_G  = 7'h42;
  localparam logic [SEG_W-1:0] SEG_H  = 7'h09;
  localparam logic [SEG_W-1:0] SEG_L  = 7'h47;
  localparam logic [SEG_W-1:0] SEG_Y  = 7'h11;
  localparam logic [SEG_W-1:0] SEG_P  = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_U  = 7'h41;
  localparam logic [SEG_W-1:0] SEG_SP = 7'h7F;

  localparam logic [CODE_W-1:0] CH_0   = 5'h00;
  localparam logic [CODE_W-1:0] CH_1   = 5'h01;
  localparam logic [CODE_W-1:0] CH_2   = 5'h02;
  localparam logic [CODE_W-1:0] CH_3   = 5'h03;
  localparam logic [CODE_W-1:0] CH_4   = 5'h04;
  localparam logic [CODE_W-1:0] CH_5   = 5'h05;
  localparam logic [CODE_W-1:0] CH_6   = 5'h06;
  localparam logic [CODE_W-1:0] CH_7   = 5'h07;
  localparam logic [CODE_W-1:0] CH_8   = 5'h08;
  localparam logic [CODE_W-1:0] CH_9   = 5'h09;
  localparam logic [CODE_W-1:0] CH_A   = 5'h0A;
  localparam logic [CODE_W-1:0] CH_B   = 5'h0B;
  localparam logic [CODE_W-1:0] CH_C   = 5'h0C;
  localparam logic [CODE_W-1:0] CH_D   = 5'h0D;
  localparam logic [CODE_W-1:0] CH_E   = 5'h0E;
  localparam logic [CODE_W-1:0] CH_F   = 5'h0F;
  localparam logic [CODE_W-1:0] CH_G   = 5'h10;
  localparam logic [CODE_W-1:0] CH_H   = 5'h11;
  localparam logic [CODE_W-1:0] CH_L   = 5'h12;
  localparam logic [CODE_W-1:0] CH_Y   = 5'h13;
  localparam logic [CODE_W-1:0] CH_P   = 5'h14;
  localparam logic [CODE_W-1:0] CH_U   = 5'h15;
  localparam logic [CODE_W-1:0] CH_SP  = 5'h1E;
  localparam logic [CODE_W-1:0] CH_BAD = 5'h1F;

  typedef struct packed {
    logic              err;
    logic              dp;
    logic [CODE_W-1:0] code;
  } seg_entry_t;

  localparam int ENTRY_W = $bits(seg_entry_t);

  // Letter O reuses the digit-0 pattern, so both come back as CH_0.
  function automatic logic [CODE_W-1:0] seg_decode(input logic [SEG_W-1:0] seg);
    case (seg)
      SEG_0:   seg_decode = CH_0;
      SEG_1:   seg_decode = CH_1;
      SEG_2:   seg_decode = CH_2;
      SEG_3:   seg_decode = CH_3;
      SEG_4:   seg_decode = CH_4;
      SEG_5:   seg_decode = CH_5;
      SEG_6:   seg_decode = CH_6;
      SEG_7:   seg_decode = CH_7;
      SEG_8:   seg_decode = CH_8;
      SEG_9:   seg_decode = CH_9;
      SEG_A:   seg_decode = CH_A;
      SEG_B:   seg_decode = CH_B;
      SEG_C:   seg_decode = CH_C;
      SEG_D:   seg_decode = CH_D;
      SEG_E:   seg_decode = CH_E;
      SEG_F:   seg_decode = CH_F;
      SEG_G:   seg_decode = CH_G;
      SEG_H:   seg_decode = CH_H;
      SEG_L:   seg_decode = CH_L;
      SEG_Y:   seg_decode = CH_Y;
      SEG_P:   seg_decode = CH_P;
      SEG_U:   seg_decode = CH_U;
      SEG_SP:  seg_decode = CH_SP;
      default: seg_decode = CH_BAD;
    endcase
  endfunction

endpackage

// File: rtl/m_seg_fifo.sv
// Generic DEPTH x WIDTH FIFO with synchronous flush; head data is read straight from storage.
// One cycle write-to-head latency; in_ready drops only when full and ignores out_ready.
module m_seg_fifo
  import m_seg_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_dat   = mem[rd_ptr];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m_seg_decoder.sv
// Decodes active-low seven-segment patterns to character codes into a DEPTH-entry FIFO.
// One cycle accept-to-head latency; in_ready low only while full; err_cnt saturates at 255.
module m_seg_decoder
  import m_seg_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_dat,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_code,
  output logic       out_dp,
  output logic       out_err,
  output logic [7:0] err_cnt
);

  seg_entry_t        wr_entry;
  seg_entry_t        rd_entry;
  logic [CODE_W-1:0] dec_code;
  logic              accept;

  assign dec_code = seg_decode(in_dat[SEG_W-1:0]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.code = dec_code;
    wr_entry.dp   = ~in_dat[7];
    wr_entry.err  = (dec_code == CH_BAD);
  end

  m_seg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dat    (wr_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (rd_entry)
  );

  assign out_code = rd_entry.code;
  assign out_dp   = rd_entry.dp;
  assign out_err  = rd_entry.err;

  // Counts only patterns actually stored; a push dropped by clr does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (accept && wr_entry.err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/m_seg_decoder.md
# m_seg_decoder

Streaming decoder that accepts 8-bit active-low seven-segment patterns, as produced by the character ROMs (bit7 = dp, bits 6..0 = g..a, 0 = lit), and turns them back into 5-bit character codes. Decoded characters are buffered in a 4-entry FIFO behind a valid/ready handshake, and unrecognised patterns are counted. It sits between any segment-pattern source and logic that needs the character identity, such as the display checker or the message comparator.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush of the FIFO and the error counter; has priority over push and pop
- in_valid  in  1  in_dat holds a pattern
- in_ready  out  1  block can accept a pattern
- in_dat  in  8  active-low segment pattern
- out_valid  out  1  head of the FIFO is valid
- out_ready  in  1  consumer takes the head
- out_code  out  5  decoded character code
- out_dp  out  1  decimal point lit (= ~in_dat[7] at accept)
- out_err  out  1  pattern unrecognised (out_code = 0x1F)
- err_cnt  out  8  saturating count of accepted unrecognised patterns

## Operation
- Decode is combinational on in_dat[6:0]; bit7 is ignored for the decode. Map (pattern hex → code):
  - Digits: 40→00, 79→01, 24→02, 30→03, 19→04, 12→05, 02→06, 78→07, 00→08, 10→09.
  - Letters: 08→0A (A), 03→0B (b), 46→0C (C), 21→0D (d), 06→0E (E), 0E→0F (F), 42→10 (G), 09→11 (H), 47→12 (L), 11→13 (y), 0C→14 (P), 41→15 (U).
  - Space: 7F→1E.
  - Any other pattern → 1F with err = 1.
- Letter O and digit 0 share pattern 40 and both decode to 00.
- Push: in_valid & in_ready stores {err, dp, code} at the write pointer.
- Pop: out_valid & out_ready advances the read pointer.
- in_ready = (count != DEPTH). It is independent of out_ready, so there is no pass-through when the FIFO is full.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- err_cnt increments on each push with err = 1 and holds at 255.
- clr:
  - empties the FIFO (count, pointers = 0) and zeroes err_cnt;
  - a coincident push is dropped and a coincident pop is ignored;
  - in_ready is still computed from pre-clear count during that cycle.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_code = 0, out_dp = 0, out_err = 0, err_cnt = 0, FIFO empty.
- Latency: a pattern accepted at edge N appears on out_* after edge N (one cycle), provided it is at the FIFO head.
- Output stability:
  - out_code, out_dp and out_err come directly from the head entry and are stable while out_valid = 1 and out_ready = 0.
  - out_valid never drops without a pop or clr.
- Throughput: one pattern per cycle sustained when the consumer holds out_ready = 1.
- Full boundary: after DEPTH pushes with no pops, in_ready = 0 from the next cycle. It returns to 1 in the cycle after the first pop.
- Empty boundary: out_valid = 0. The out_* data lines then show the entry at the read pointer, which is don't-care.
- Reset mid-stream: rst_n low immediately empties the FIFO and zeroes err_cnt. Pending entries are lost.

## Structure
- The shared package holds:
  - the 23 pattern constants (SEG_0 … SEG_U, SEG_SP);
  - the code constants (CH_0 … CH_U, CH_SP = 5'h1E, CH_BAD = 5'h1F);
  - the 7-bit segment-pattern width.
- The ROMs and this decoder both use these constants.
- Sub-module m_seg_fifo: generic DEPTH×7-bit synchronous FIFO with clr and the full/empty handling described above. The top level holds the decode function and err_cnt.

## Test plan
- Feed the ROM "HELLO" sequence 89, 86, C7, C7, C0 with out_ready = 1 → codes 11, 0E, 12, 12, 00, each one cycle after accept; out_err = 0; err_cnt = 0.
- Feed "GOOdbyE" C2, C0, C0, A1, 83, 91, 86, FF → codes 10, 00, 00, 0D, 0B, 13, 0E, 1E.
- Dp and error handling: 40 → code 00 with out_dp = 1. FE → code 1F with out_err = 1 and err_cnt = 1. Then 300 × FE → err_cnt saturates at 255.
- Backpressure: hold out_ready = 0 and push 5 patterns back-to-back → in_ready falls after the 4th accept and the 5th waits. Release → outputs appear in order, and in_ready rises the cycle after the first pop.
- Simultaneous push and pop at count = 2 for 10 cycles → count stays at 2, order is preserved, pointers wrap correctly.
- Flush and reset: assert clr with 3 entries buffered and in_valid = 1 → next cycle out_valid = 0, err_cnt = 0, input not stored. Repeat with rst_n pulsed low mid-stream → same result asynchronously.
